// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - Y86-64 icodes, status codes and hazard-unit state shared by the control slice.
package pipe_pkg;

    localparam int unsigned I_HALT   = 0;
    localparam int unsigned I_NOP    = 1;
    localparam int unsigned I_RRMOVQ = 2;
    localparam int unsigned I_IRMOVQ = 3;
    localparam int unsigned I_RMMOVQ = 4;
    localparam int unsigned I_MRMOVQ = 5;
    localparam int unsigned I_OPQ    = 6;
    localparam int unsigned I_JXX    = 7;
    localparam int unsigned I_CALL   = 8;
    localparam int unsigned I_RET    = 9;
    localparam int unsigned I_PUSHQ  = 10;
    localparam int unsigned I_POPQ   = 11;

    localparam int unsigned STAT_AOK = 1;
    localparam int unsigned STAT_HLT = 2;
    localparam int unsigned STAT_ADR = 3;
    localparam int unsigned STAT_INS = 4;

    localparam int unsigned RNONE = 15;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_HALTED
    } pipe_state_e;

    // Instructions that touch data memory in the Memory stage.
    function automatic logic is_mem_op(input int unsigned icode);
        return icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    endfunction

endpackage

// File: rtl/pipe_mem_wait_timer.sv
// rtl/pipe_mem_wait_timer.sv - counts consecutive data-memory wait cycles and pulses on timeout.
module pipe_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    output logic timeout_o
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          at_limit;

    // The counter holds the number of wait cycles already spent, so the
    // MEM_TIMEOUT-th consecutive busy cycle is the one that fires.
    assign at_limit  = (cnt_q == TW'(MEM_TIMEOUT - 1));
    assign timeout_o = wait_i && at_limit;

    always_comb begin
        cnt_d = '0;
        if (wait_i && !at_limit) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Y86-64 stall/bubble control with memory-wait FSM and sticky halt.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ICODE_W     = 4,
    parameter int REG_W       = 4,
    parameter int STAT_W      = 3,
    parameter int MEM_TIMEOUT = 64
`ifdef PIPE_PERF_CNT_EN
    ,parameter int CNT_W      = 32
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    input  logic               dmem_busy,
    output logic               F_stall,
    output logic               D_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_stall,
    output logic               M_bubble,
    output logic               W_stall,
    output logic               W_bubble,
    output logic               set_cc,
    output logic               halted,
    output logic               mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,output logic [CNT_W-1:0]  perf_cycles,
    output logic [CNT_W-1:0]   perf_stalls,
    output logic [CNT_W-1:0]   perf_bubbles,
    output logic [CNT_W-1:0]   perf_memwait
`endif
);

    localparam logic [REG_W-1:0] REG_NONE = {REG_W{1'b1}};

    pipe_state_e state_q, state_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        exc_m, exc_w, lu, ret, mis, wait_now, tmo;

    assign exc_m = (m_stat != STAT_W'(STAT_AOK));
    assign exc_w = (W_stat != STAT_W'(STAT_AOK));
    assign lu    = (E_icode == ICODE_W'(I_MRMOVQ) || E_icode == ICODE_W'(I_POPQ))
                && (E_dstM != REG_NONE)
                && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign ret   = (D_icode == ICODE_W'(I_RET)) || (E_icode == ICODE_W'(I_RET))
                || (M_icode == ICODE_W'(I_RET));
    assign mis   = (E_icode == ICODE_W'(I_JXX)) && !e_cnd;

    // Memory stalls in the very cycle it is busy, so the wait behaviour starts
    // while still in RUN; a writeback exception overrides the wait.
    assign wait_now = dmem_busy && !exc_w
                   && ((state_q == ST_MEMWAIT)
                    || (state_q == ST_RUN && is_mem_op(32'(M_icode))));

    pipe_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wait_i    (wait_now),
        .timeout_o (tmo)
    );

    always_comb begin
        state_d       = state_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN, ST_MEMWAIT: begin
                if (exc_w) begin
                    state_d = ST_HALTED;
                end else if (tmo) begin
                    state_d       = ST_HALTED;
                    mem_timeout_d = 1'b1;
                end else if (wait_now) begin
                    state_d = ST_MEMWAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_stall     = 1'b0;
        M_bubble    = 1'b0;
        W_stall     = 1'b0;
        W_bubble    = 1'b0;
        set_cc      = 1'b0;
        halted      = 1'b0;
        mem_timeout = mem_timeout_q;
        if (!rst_n) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else if (state_q == ST_HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            M_stall = 1'b1;
            W_stall = 1'b1;
            halted  = 1'b1;
        end else if (wait_now) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else begin
            F_stall  = lu | ret;
            D_stall  = lu;
            D_bubble = mis | (ret & !lu);
            E_bubble = mis | lu;
            M_bubble = exc_m | exc_w;
            W_stall  = exc_w;
            set_cc   = (E_icode == ICODE_W'(I_OPQ)) & !exc_m & !exc_w;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, stl_q, bub_q, mw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            stl_q <= '0;
            bub_q <= '0;
            mw_q  <= '0;
        end else begin
            if (state_q != ST_HALTED && cyc_q != '1)             cyc_q <= cyc_q + 1'b1;
            if (F_stall && stl_q != '1)                          stl_q <= stl_q + 1'b1;
            if ((D_bubble | E_bubble) && bub_q != '1)            bub_q <= bub_q + 1'b1;
            if (state_q == ST_MEMWAIT && mw_q != '1)             mw_q  <= mw_q + 1'b1;
        end
    end

    assign perf_cycles  = cyc_q;
    assign perf_stalls  = stl_q;
    assign perf_bubbles = bub_q;
    assign perf_memwait = mw_q;
`endif

endmodule
